shared_port_arbiter: RTL and testbench

SHARED_PORT_ARBITER -- requirements
Module: shared_port_arbiter

---
 rtl/shared_port_arbiter_if.sv | 35 +++
 rtl/shared_port_arbiter.sv | 128 ++++++++++++
 tb/tb_shared_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/shared_port_arbiter_if.sv
// shared_port_arbiter_if
// Bundles the request/grant signals of the shared-port arbiter.
//   req       : level request per requester (driven by the requesters)
//   gnt       : registered one-hot grant, all-zero when nothing is granted
//   gnt_valid : OR of gnt
//   gnt_id    : index of the granted requester, 0 when gnt_valid is low
//   timeout   : one-cycle pulse when a grant is revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
interface shared_port_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IDW-1:0]  gnt_id;
    logic            timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );
endinterface

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter
// Round-robin arbiter for one shared datapath with a per-grant hold limit.
// A requester keeps the grant while its req stays high, for at most MAX_HOLD
// cycles; every grant is followed by at least one all-zero cycle, and the
// round-robin pointer moves past the last owner so other requesters get in.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : shared_port_arbiter_if.slave (req in; gnt, gnt_valid, gnt_id,
//           timeout out)
// Parameters: NREQ (2..8) requesters, MAX_HOLD (1..255) max grant length.
// The interface instance must be built with the same NREQ.
module shared_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input logic                  clk,
    input logic                  reset,
    shared_port_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg,    state_next;
    logic [NREQ-1:0] gnt_reg,      gnt_next;
    logic [IDW-1:0]  gnt_id_reg,   gnt_id_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [IDW-1:0]  rr_ptr_reg,   rr_ptr_next;
    logic            timeout_reg,  timeout_next;

    // Requests rotated so that position 0 is the requester at rr_ptr.
    // The sum is one bit wider so the modulo-NREQ wrap also works when NREQ
    // is not a power of two.
    logic [IDW-1:0]  rot_idx [NREQ];
    logic [NREQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
            assign rot_idx[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                           : sum[IDW-1:0];
            assign rot_req[gi]  = bus.req[rot_idx[gi]];
        end
    endgenerate

    // First requester at or after rr_ptr.
    logic           sel_found;
    logic [IDW-1:0] sel_id;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found && rot_req[k]) begin
                sel_found = 1'b1;
                sel_id    = rot_idx[k];
            end
        end
    end

    // Pointer value after the current owner releases: owner + 1, wrapped.
    logic [IDW-1:0] ptr_after;
    assign ptr_after = (gnt_id_reg == IDW'(NREQ - 1)) ? '0 : gnt_id_reg + IDW'(1);

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        hold_cnt_next = hold_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next       = BUSY;
                    gnt_next         = '0;
                    gnt_next[sel_id] = 1'b1;
                    gnt_id_next      = sel_id;
                    hold_cnt_next    = HW'(1);
                end
            end
            BUSY: begin
                // Voluntary release takes priority over the limit, so
                // dropping req in the last allowed cycle is not a timeout.
                if (!bus.req[gnt_id_reg] || hold_cnt_reg >= HW'(MAX_HOLD)) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    gnt_id_next   = '0;
                    hold_cnt_next = '0;
                    rr_ptr_next   = ptr_after;
                    timeout_next  = bus.req[gnt_id_reg];
                end else begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            hold_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            hold_cnt_reg <= hold_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_valid = |gnt_reg;
    assign bus.gnt_id    = gnt_id_reg;
    assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter
// Drives shared_port_arbiter (NREQ=4, MAX_HOLD=8) with directed and random
// request patterns. Expected outputs come from a behavioural model and are
// queued per clock; a monitor compares them against the DUT after each edge.
module tb_shared_port_arbiter;
    localparam int N    = 4;
    localparam int MAXH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shared_port_arbiter_if #(.NREQ(N)) bus ();

    shared_port_arbiter #(.NREQ(N), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when nobody holds the port; held = cycles granted so far;
    // ptr = where the next search starts.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        bit found;
        m_to = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_held == MAXH) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    typedef struct {
        logic [N-1:0] gnt;
        int           id;
        bit           to;
    } exp_t;

    exp_t sb[$];
    bit   mon_en = 1'b0;

    // Apply req for the coming edge and queue the expected result.
    task automatic drive_now(input logic [N-1:0] r);
        exp_t e;
        logic [N-1:0] g;
        bus.req = r;
        model_step(r);
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        e.gnt = g;
        e.id  = (m_owner >= 0) ? m_owner : 0;
        e.to  = m_to;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] r);
        @(negedge clk);
        drive_now(r);
    endtask

    // ---------------- monitor ----------------
    int           grant_log[$];
    int           len_log[$];
    int           tout_count = 0;
    logic [N-1:0] prev_gnt   = '0;
    int           cur_len    = 0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("gnt",       int'(bus.gnt),       int'(e.gnt));
                    chk("gnt_id",    int'(bus.gnt_id),    e.id);
                    chk("gnt_valid", int'(bus.gnt_valid), int'(e.gnt != '0));
                    chk("timeout",   int'(bus.timeout),   int'(e.to));
                    chk("tout_excl", int'(bus.timeout & bus.gnt_valid), 0);
                end
                if (bus.gnt != '0) begin
                    if (prev_gnt == '0) begin
                        grant_log.push_back(int'(bus.gnt));
                        cur_len = 1;
                    end else begin
                        cur_len++;
                    end
                end else if (prev_gnt != '0) begin
                    len_log.push_back(cur_len);
                    $display("grant %b len=%0d timeout=%0b", prev_gnt, cur_len, bus.timeout);
                end
                if (bus.timeout) tout_count++;
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_order[5];
        int t0;
        logic [N-1:0] r;
        exp_order = '{1, 2, 4, 8, 1};

        // Reset state, including a clock edge while reset is held.
        bus.req = '0;
        repeat (2) @(negedge clk);
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        chk("rst_gnt",       int'(bus.gnt),       0);
        chk("rst_gnt_valid", int'(bus.gnt_valid), 0);
        chk("rst_gnt_id",    int'(bus.gnt_id),    0);
        chk("rst_timeout",   int'(bus.timeout),   0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        drive_now('0);

        // Fairness: all requesting constantly.
        grant_log.delete();
        len_log.delete();
        tout_count = 0;
        repeat (45) cycle(4'b1111);
        cycle(4'b0000);
        chk("fair_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
            chk("fair_len",   (i < len_log.size())   ? len_log[i]   : -1, MAXH);
        end
        chk("fair_timeouts", tout_count, 5);

        // Voluntary release, then wrap of the pointer from 3 to 0.
        t0 = tout_count;
        repeat (3) cycle(4'b0100);
        cycle(4'b0000);
        repeat (2) cycle(4'b0101);
        repeat (2) cycle(4'b0000);
        chk("release_no_timeout", tout_count - t0, 0);

        // Owner 1 drops on the same cycle requester 3 rises.
        repeat (3) cycle(4'b0010);
        repeat (3) cycle(4'b1000);
        repeat (2) cycle(4'b0000);

        // Hold limit boundary: 8 cycles is a release, 9 is a timeout.
        t0 = tout_count;
        repeat (8) cycle(4'b0100);
        repeat (2) cycle(4'b0000);
        chk("limit8_timeouts", tout_count - t0, 0);
        t0 = tout_count;
        repeat (9) cycle(4'b0100);
        repeat (2) cycle(4'b0000);
        chk("limit9_timeouts", tout_count - t0, 1);

        // Asynchronous reset in the middle of a grant.
        cycle(4'b0001);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_gnt",       int'(bus.gnt),       0);
        chk("async_rst_gnt_valid", int'(bus.gnt_valid), 0);
        chk("async_rst_gnt_id",    int'(bus.gnt_id),    0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        prev_gnt = '0;
        mon_en   = 1'b1;
        drive_now(4'b1010);
        repeat (3) cycle(4'b1010);
        repeat (2) cycle(4'b0000);

        // Random traffic: requests mostly persist so grants reach the limit.
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, 15));
            cycle(r);
        end
        cycle(4'b0000);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
